// File: rtl/aes_shift_rows_pipe.sv
// Pipelined ShiftRows / InvShiftRows for Rijndael states of NB = 4, 6 or 8 columns.
// Optional unpermuted pass-through enabled by defining AES_SHIFT_ROWS_BYPASS_EN.
module aes_shift_rows_pipe #(
   parameter int unsigned NB          = 4,
   parameter int unsigned PIPE_STAGES = 1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic                               in_inv,
`ifdef AES_SHIFT_ROWS_BYPASS_EN
   input  logic                               in_bypass,
`endif
   input  logic [32*NB-1:0]                   in_data,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [32*NB-1:0]                   out_data,
   output logic [$clog2(PIPE_STAGES+1)-1:0]   occupancy
);

   localparam int unsigned W     = 32 * NB;
   localparam int unsigned OCC_W = $clog2(PIPE_STAGES + 1);
   localparam int unsigned LAST  = PIPE_STAGES - 1;

   generate
      if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
         $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
      end
      if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
         $error("aes_shift_rows_pipe: PIPE_STAGES must be in 1..4");
      end
   endgenerate

   logic [W-1:0]             fwd_c;
   logic [W-1:0]             inv_c;
   logic [W-1:0]             xform_c;
   logic [PIPE_STAGES-1:0]   valid_q;
   logic [PIPE_STAGES-1:0]   valid_d;
   logic [PIPE_STAGES-1:0]   adv_c;
   logic [PIPE_STAGES-1:0]   load_c;
   logic [W-1:0]             data_q [PIPE_STAGES];
   logic [W-1:0]             data_d [PIPE_STAGES];
   logic [OCC_W-1:0]         occ_q;
   logic [OCC_W-1:0]         occ_d;

   // Byte permutation wiring: row r rotates by off_r columns (rows 2,3 skip one extra at NB=8).
   generate
      for (genvar c = 0; c < NB; c++) begin : g_col
         for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int unsigned OFF   = (NB == 8 && r >= 2) ? r + 1 : r;
            localparam int unsigned SRC_F = (c + OFF) % NB;
            localparam int unsigned SRC_I = (c + NB - OFF) % NB;
            localparam int unsigned DST   = W - 1 - 8 * (4 * c + r);
            localparam int unsigned SF    = W - 1 - 8 * (4 * SRC_F + r);
            localparam int unsigned SI    = W - 1 - 8 * (4 * SRC_I + r);
            assign fwd_c[DST -: 8] = in_data[SF -: 8];
            assign inv_c[DST -: 8] = in_data[SI -: 8];
         end
      end
   endgenerate

   always_comb begin
      xform_c = in_inv ? inv_c : fwd_c;
`ifdef AES_SHIFT_ROWS_BYPASS_EN
      if (in_bypass) begin
         xform_c = in_data;
      end
`endif
   end

   // Backpressure ripple: a stage advances when its successor can load.
   always_comb begin
      logic ahead;
      adv_c  = '0;
      load_c = '0;
      ahead  = out_ready;
      for (int k = LAST; k >= 0; k--) begin
         adv_c[k]  = valid_q[k] & ahead;
         load_c[k] = ~valid_q[k] | adv_c[k];
         ahead     = load_c[k];
      end
   end

   assign in_ready = rst_n & load_c[0];

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      occ_d   = '0;
      if (load_c[0]) begin
         valid_d[0] = in_valid;
         if (in_valid) begin
            data_d[0] = xform_c;
         end
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
         if (load_c[k]) begin
            valid_d[k] = valid_q[k-1];
            if (valid_q[k-1]) begin
               data_d[k] = data_q[k-1];
            end
         end
      end
      for (int k = 0; k < PIPE_STAGES; k++) begin
         occ_d = occ_d + OCC_W'(valid_d[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
         occ_q   <= '0;
         for (int k = 0; k < PIPE_STAGES; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         occ_q   <= occ_d;
         for (int k = 0; k < PIPE_STAGES; k++) begin
            data_q[k] <= data_d[k];
         end
      end
   end

   assign out_valid = valid_q[LAST];
   assign out_data  = data_q[LAST];
   assign occupancy = occ_q;

endmodule

// File: doc/aes_shift_rows_pipe.md
Name: aes_shift_rows_pipe

Overview:
- Parametrised, pipelined ShiftRows / InvShiftRows unit for the AES/Rijndael round datapath. Sits between SubBytes and MixColumns.
- Generalises the fixed 128-bit combinational ShiftRows in three ways:
  - Rijndael block width Nb = 4, 6 or 8 columns.
  - Per-transaction direction select (forward or inverse).
  - Configurable register stages with a valid/ready handshake and full backpressure.

Parameters:
- NB, 4, number of 32-bit state columns; legal values 4, 6, 8 (elaboration error otherwise).
- PIPE_STAGES, 1, number of register stages; legal values 1..4.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  unit can accept the input this cycle.
- in_inv  in  1  0 = ShiftRows, 1 = InvShiftRows; sampled with in_data.
- in_data  in  32*NB  input state, column-major.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accepts the output.
- out_data  out  32*NB  shifted state, column-major.
- occupancy  out  $clog2(PIPE_STAGES+1)  number of valid stages currently held.

Behaviour:
- Packing: byte (row r, col c) sits at bits [32*NB-1-8*(4c+r) -: 8]. Column 0 occupies the MSBs; row 0 is the MSB of each column.
- Row offsets off_r:
  - NB=4 or 6: 0, 1, 2, 3.
  - NB=8: 0, 1, 3, 4.
- Transform:
  - Forward: out[r][c] = in[r][(c+off_r) mod NB].
  - Inverse: out[r][c] = in[r][(c-off_r+NB) mod NB].
  - Pure byte permutation; no arithmetic.
- Placement: the transform is combinational from in_data/in_inv into stage-1 registers. Later stages are pure delay.
- Handshake:
  - Transfer occurs when valid && ready on the same edge.
  - Each stage k holds valid_k and data_k. Stage k loads when !valid_k or stage k advances.
  - Last stage advances on out_ready. in_ready = !valid_1 || advance_1.
  - Combinational ready path back to the input is permitted; no skid buffer.
- Latency: PIPE_STAGES cycles from input transfer to out_valid, with no stall. Throughput is one transfer per cycle with out_ready held high.
- Stall:
  - out_valid && !out_ready: out_data and out_valid hold stable.
  - Bubbles upstream still collapse, so a stall leaves no gaps.
- Ordering: strictly in order. in_inv travels with its data, and mixed-direction back-to-back transfers are legal.
- Reset:
  - While rst_n=0 on an edge: all valid_k <= 0, all data_k <= 0, occupancy = 0.
  - in_ready is forced 0 while rst_n is low.
  - Reset mid-operation discards in-flight states with no output.
- After reset: out_valid=0, out_data=0, in_ready=1 on the first cycle with rst_n=1.
- Simultaneous events:
  - Pipeline full with out_ready=1 and in_valid=1: input and output transfer on the same edge; occupancy unchanged.
- occupancy is registered-consistent: it equals the count of valid_k after each edge.
- X-safety: data registers load only on transfer, so in_data is don't-care when in_valid=0.

Optional Feature:
- Macro: AES_SHIFT_ROWS_BYPASS_EN.
- When defined:
  - Adds input port in_bypass (1 bit) sampled with in_data.
  - in_bypass=1 passes the state unpermuted (out = in), overriding in_inv. It keeps the same latency and ordering.
  - Used for the Rijndael key-whitening-only pass and for debug.
- When undefined: port absent and the transform is always applied.

Test Plan:
- NB=4, PIPE_STAGES=1, fwd, in_data=0xd42711aee0bf98f1b8b45de51e415230 -> one cycle later out_data=0xd4bf5d30e0b452aeb84111f11e2798e5 (FIPS-197 round 1).
- NB=4, in_data bytes 00..0f (byte index 4c+r):
  - fwd -> 0x00050a0f04090e03080d02070c01060b.
  - inv -> 0x000d0a070401 0e0b0805020f0c090603 (concatenated; forward then inverse round-trips to input).
- NB=8, fwd, in_data bytes 00..1f -> col0 = 00 05 0e 13, col4 = 10 15 1e 03 (offsets 0,1,3,4); inverse restores input.
- PIPE_STAGES=3:
  - Stream 8 states with alternating in_inv and out_ready held 0 for cycles 4..9.
  - Checks: no loss or duplication, in order; occupancy peaks at 3; in_ready=0 while full and stalled; out_data stable during the stall.
- Assert rst_n=0 with 2 states in flight -> out_valid=0 and occupancy=0 next cycle, in_ready=0 during reset, no stale output after release.
- With AES_SHIFT_ROWS_BYPASS_EN, in_bypass=1, in_inv=1 -> out_data == in_data after PIPE_STAGES cycles.
